// File: rtl/adder4_seq_ctrl.sv
// Nibble-serial W-bit adder: one shared 4-bit ripple adder, carry registered between nibbles.
// Optional subtract mode (SUB port) is enabled by defining ADDSEQ_SUB_EN.

module adder4_2 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] s_o,
   output logic       cout_o
);
   logic [4:0] c_s;

   assign c_s[0] = cin_i;

   for (genvar k = 0; k < 4; k++) begin : g_fa
      assign s_o[k]     = a_i[k] ^ b_i[k] ^ c_s[k];
      assign c_s[k + 1] = (a_i[k] & b_i[k]) | (c_s[k] & (a_i[k] ^ b_i[k]));
   end

   assign cout_o = c_s[4];
endmodule

module adder4_seq_ctrl #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
`ifdef ADDSEQ_SUB_EN
   input  logic         sub_i,
`endif
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] s_o,
   output logic         cout_o
);
   localparam int N  = W / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   if ((W % 4) != 0 || W < 4) begin : g_bad_width
      $error("adder4_seq_ctrl: W must be a multiple of 4 and >= 4");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  opa_q, opa_d;
   logic [W-1:0]  opb_q, opb_d;
   logic          cin_q, cin_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  s_q, s_d;
   logic          cout_q, cout_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          inv_s;
   logic          sub_cap_s;
   logic [3:0]    add_a_s, add_b_s, add_s_s;
   logic          add_cin_s, add_cout_s;

`ifdef ADDSEQ_SUB_EN
   logic          sub_q, sub_d;
   assign inv_s     = sub_q;
   assign sub_cap_s = sub_i;
`else
   assign inv_s     = 1'b0;
   assign sub_cap_s = 1'b0;
`endif

   // Subtract is A + ~B + 1, so the forced carry-in is folded into cin_q at capture.
   assign add_a_s   = opa_q[{idx_q, 2'b00} +: 4];
   assign add_b_s   = opb_q[{idx_q, 2'b00} +: 4] ^ {4{inv_s}};
   assign add_cin_s = (idx_q == {IW{1'b0}}) ? cin_q : carry_q;

   adder4_2 u_adder (
      .a_i    (add_a_s),
      .b_i    (add_b_s),
      .cin_i  (add_cin_s),
      .s_o    (add_s_s),
      .cout_o (add_cout_s)
   );

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= {IW{1'b0}};
         opa_q   <= {W{1'b0}};
         opb_q   <= {W{1'b0}};
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         s_q     <= {W{1'b0}};
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef ADDSEQ_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         cin_q   <= cin_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef ADDSEQ_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

   // Next-state, nibble write-back and output flag decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      cin_d   = cin_q;
      carry_d = carry_q;
      s_d     = s_q;
      cout_d  = cout_q;
`ifdef ADDSEQ_SUB_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d = ST_RUN;
               idx_d   = {IW{1'b0}};
               opa_d   = a_i;
               opb_d   = b_i;
               cin_d   = cin_i | sub_cap_s;
               carry_d = 1'b0;
               s_d     = {W{1'b0}};
               cout_d  = 1'b0;
`ifdef ADDSEQ_SUB_EN
               sub_d   = sub_i;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            s_d[{idx_q, 2'b00} +: 4] = add_s_s;
            carry_d = add_cout_s;
            if (idx_q == IDX_LAST) begin
               cout_d  = add_cout_s;
               idx_d   = {IW{1'b0}};
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IDX_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign s_o    = s_q;
   assign cout_o = cout_q;
endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Directed self-checking bench for adder4_seq_ctrl (W=16); define ADDSEQ_SUB_EN to cover subtract.

module tb_adder4_seq_ctrl;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef ADDSEQ_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         cout;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   adder4_seq_ctrl #(.W(W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .a_i     (a),
      .b_i     (b),
      .cin_i   (cin),
`ifdef ADDSEQ_SUB_EN
      .sub_i   (sub),
`endif
      .busy_o  (busy),
      .done_o  (done),
      .s_o     (s),
      .cout_o  (cout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic bsy, input logic dn,
                            input logic [W-1:0] sum, input logic co);
      check({tag, ".busy"}, 32'(busy), 32'(bsy));
      check({tag, ".done"}, 32'(done), 32'(dn));
      check({tag, ".s"},    32'(s),    32'(sum));
      check({tag, ".cout"}, 32'(cout), 32'(co));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
`ifdef ADDSEQ_SUB_EN
      sub = 1'b0;
`endif
      #1;
      check_out("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_out("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

      // T1: busy for 4 cycles, done after 4th edge
      a = 16'h1234; b = 16'h0FFF; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      check("t1.busy0", 32'(busy), 32'd1);
      check("t1.done0", 32'(done), 32'd0);
      for (int i = 1; i < 4; i++) begin
         tick();
         check($sformatf("t1.busy%0d", i), 32'(busy), 32'd1);
         check($sformatf("t1.done%0d", i), 32'(done), 32'd0);
      end
      tick();
      check_out("t1.res", 1'b0, 1'b1, 16'h2233, 1'b0);
      tick();
      check_out("t1.hold", 1'b0, 1'b0, 16'h2233, 1'b0);

      // T2: carry through all nibbles
      a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("t2.sclr", 32'(s), 32'h0);
      repeat (4) tick();
      check_out("t2.res", 1'b0, 1'b1, 16'h0000, 1'b1);

      // T3: cin only, then START held in DONE (back-to-back)
      tick();
      a = 16'h0000; b = 16'h0000; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_out("t3.res", 1'b0, 1'b1, 16'h0001, 1'b0);
      a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check_out("t3.b2b", 1'b1, 1'b0, 16'h0000, 1'b0);
      repeat (3) tick();
      check("t3.nodone", 32'(done), 32'd0);
      tick();
      check_out("t3.res2", 1'b0, 1'b1, 16'h1000, 1'b0);

      // T4: START during RUN is ignored
      tick();
      a = 16'h1234; b = 16'h0FFF; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("t4.nodone", 32'(done), 32'd0);
      tick();
      check_out("t4.res", 1'b0, 1'b1, 16'h2233, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t4.once%0d", i), 32'({busy, done}), 32'd0);
      end

      // T5: reset mid-RUN aborts at once
      a = 16'h1234; b = 16'h0FFF; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("t5.busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_out("t5.rst", 1'b0, 1'b0, 16'h0000, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out($sformatf("t5.quiet%0d", i), 1'b0, 1'b0, 16'h0000, 1'b0);
      end
      a = 16'hFFFF; b = 16'h0001; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_out("t5.res", 1'b0, 1'b1, 16'h0001, 1'b1);

`ifdef ADDSEQ_SUB_EN
      // T6: subtract, CIN ignored
      tick();
      a = 16'h0005; b = 16'h0007; cin = 1'b0; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; sub = 1'b0;
      repeat (4) tick();
      check_out("t6.neg", 1'b0, 1'b1, 16'hFFFE, 1'b0);
      a = 16'h0009; b = 16'h0004; cin = 1'b1; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; sub = 1'b0;
      repeat (4) tick();
      check_out("t6.pos", 1'b0, 1'b1, 16'h0005, 1'b1);
      a = 16'h0009; b = 16'h0004; cin = 1'b1; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_out("t6.add", 1'b0, 1'b1, 16'h000E, 1'b0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
